// File: rtl/eq2_operand_loader_pkg.sv
// Shared types for the eq2 operand loader.
// FSM encodings and debounce lengths.
package eq2_operand_loader_pkg;

  localparam int DB_CYCLES_BOARD = 2000000;
  localparam int DB_CYCLES_SIM   = 4;

  // 2'd3 is unused and recovers to WAIT_A
  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    READY  = 2'd2
  } state_t;

endpackage

// File: rtl/eq2_operand_loader_btn_debounce.sv
// Button conditioner: 2-flop sync, debounce, rise pulse.
// Ports: clk, reset_n, raw (async button), press (1-cycle pulse).
module eq2_operand_loader_btn_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          stable;
  logic          stable_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
    end else begin
      s1       <= raw;
      s2       <= s1;
      stable_q <= stable;
      // any agreeing cycle restarts the count
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CMAX) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press = stable & ~stable_q;

endmodule

// File: rtl/eq2_operand_loader.sv
// Captures operands A then B from switches on debounced LOAD;
// CLEAR restarts. Ports: clk, reset_n, sw, btn_load, btn_clr,
// a, b, a_loaded, b_loaded, cmp_valid.
module eq2_operand_loader
  import eq2_operand_loader_pkg::*;
#(
  parameter int W         = 2,
  parameter int DB_CYCLES = DB_CYCLES_BOARD
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] sw,
  input  logic         btn_load,
  input  logic         btn_clr,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic         a_loaded,
  output logic         b_loaded,
  output logic         cmp_valid
);

  logic load_press;
  logic clr_press;

  eq2_operand_loader_btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_load (
    .clk    (clk),
    .reset_n(reset_n),
    .raw    (btn_load),
    .press  (load_press)
  );

  eq2_operand_loader_btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_clr (
    .clk    (clk),
    .reset_n(reset_n),
    .raw    (btn_clr),
    .press  (clr_press)
  );

  state_t       state;
  state_t       state_n;
  logic [W-1:0] a_n;
  logic [W-1:0] b_n;
  logic         al_n;
  logic         bl_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= WAIT_A;
      a        <= '0;
      b        <= '0;
      a_loaded <= 1'b0;
      b_loaded <= 1'b0;
    end else begin
      state    <= state_n;
      a        <= a_n;
      b        <= b_n;
      a_loaded <= al_n;
      b_loaded <= bl_n;
    end
  end

  always_comb begin
    state_n = state;
    a_n     = a;
    b_n     = b;
    al_n    = a_loaded;
    bl_n    = b_loaded;
    // CLEAR beats a coincident LOAD
    if (clr_press) begin
      state_n = WAIT_A;
      a_n     = '0;
      b_n     = '0;
      al_n    = 1'b0;
      bl_n    = 1'b0;
    end else begin
      unique case (1'b1)
        (state == WAIT_A): begin
          if (load_press) begin
            a_n     = sw;
            al_n    = 1'b1;
            state_n = WAIT_B;
          end
        end
        (state == WAIT_B): begin
          if (load_press) begin
            b_n     = sw;
            bl_n    = 1'b1;
            state_n = READY;
          end
        end
        (state == READY): begin
          state_n = READY;
        end
        default: begin
          state_n = WAIT_A;
          a_n     = '0;
          b_n     = '0;
          al_n    = 1'b0;
          bl_n    = 1'b0;
        end
      endcase
    end
  end

  assign cmp_valid = (state == READY);

endmodule
